// File: rtl/alu_uart_if.sv
// alu_uart_if: collects operand A, operand B and an opcode from a byte
// receiver, drives them to an external ALU, then transmits the result byte
// followed by a flags byte {5'b0, negative, zero, carry}.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_A   | idle, next received byte is operand A
// WAIT_B   | operand A held, waiting for operand B (inter-byte timeout)
// WAIT_OP  | operands held, waiting for opcode byte (inter-byte timeout)
// EXEC     | one cycle: capture ALU result/flags, launch result byte
// WAIT_RES | result byte in flight, waiting for transmitter done
// WAIT_FLG | flags byte in flight, waiting for transmitter done
module alu_uart_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned OP_WIDTH       = 6,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_alu_negative,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_rx_drop
);

    typedef enum logic [2:0] {
        S_WAIT_A   = 3'd0,
        S_WAIT_B   = 3'd1,
        S_WAIT_OP  = 3'd2,
        S_EXEC     = 3'd3,
        S_WAIT_RES = 3'd4,
        S_WAIT_FLG = 3'd5
    } state_t;

    // Counter is sized to hold TIMEOUT_CYCLES-1; a zero timeout keeps a 1-bit stub.
    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  rx_drop_q, rx_drop_d;
    logic [2:0]            flags_q, flags_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_hit;
    logic                  tx_ack;

    // The final idle cycle of the window is the one in which the counter sits at CNT_LAST.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    // A done pulse coinciding with our own start pulse belongs to an earlier byte.
    assign tx_ack      = i_tx_done && !tx_start_q;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            rx_drop_q  <= 1'b0;
            flags_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            rx_drop_q  <= rx_drop_d;
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and datapath updates; counter only runs while a sequence is partial.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        flags_d    = flags_q;
        cnt_d      = '0;
        rx_drop_d  = i_rx_done && (state_q inside {S_EXEC, S_WAIT_RES, S_WAIT_FLG});
        case (state_q)
            S_WAIT_A: begin
                if (i_rx_done) begin
                    a_d     = DATA_WIDTH'(i_rx_data);
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (i_rx_done) begin
                    b_d     = DATA_WIDTH'(i_rx_data);
                    state_d = S_WAIT_OP;
                end else if (timeout_hit) begin
                    state_d = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[OP_WIDTH-1:0];
                    state_d = S_EXEC;
                end else if (timeout_hit) begin
                    state_d = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                flags_d    = {i_alu_negative, i_alu_zero, i_alu_carry};
                tx_data_d  = 8'(i_alu_result);
                tx_start_d = 1'b1;
                state_d    = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (tx_ack) begin
                    tx_data_d  = {5'b0, flags_q};
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT_FLG;
                end
            end
            S_WAIT_FLG: begin
                if (tx_ack) begin
                    state_d = S_WAIT_A;
                end
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    // Outputs: registered values plus the busy decode.
    always_comb begin
        o_alu_a    = a_q;
        o_alu_b    = b_q;
        o_alu_op   = op_q;
        o_tx_data  = tx_data_q;
        o_tx_start = tx_start_q;
        o_rx_drop  = rx_drop_q;
        o_busy     = (state_q inside {S_EXEC, S_WAIT_RES, S_WAIT_FLG});
    end

endmodule
